// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for one asynchronous SRAM bank.
// Port 0 (display fetch) has priority; port 1 is protected against starvation.

module sram_arbiter_param_chk #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) ();
    // Writes need at least one cycle with WE low, so zero wait cycles is rejected.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_arbiter: WAIT_CYCLES must be in 1..15 so writes get a WE low strobe");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("sram_arbiter: STARVE_LIMIT must be in 1..15");
    end
endmodule

module sram_arbiter #(
    parameter int ADDR_WIDTH   = 19,
    parameter int DATA_WIDTH   = 8,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rvalid,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rvalid,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_TURN   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    sram_arbiter_param_chk #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_param_chk ();

    state_t                state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic [3:0]            starve_r, starve_s;
    logic                  we_r, we_s;
    logic                  port_r, port_s;
    logic                  grant_p1_s, win_we_s;
    logic [ADDR_WIDTH-1:0] win_addr_s;
    logic [DATA_WIDTH-1:0] win_wdata_s;
    logic                  p0_ack_s, p1_ack_s, p0_rvalid_s, p1_rvalid_s;
    logic [DATA_WIDTH-1:0] p0_rdata_s, p1_rdata_s;
    logic [ADDR_WIDTH-1:0] sram_addr_s;
    logic [DATA_WIDTH-1:0] sram_dq_out_s;
    logic                  sram_dq_oe_s, sram_ce_n_s, sram_oe_n_s, sram_we_n_s;

    // Port 1 wins when alone or once port 0 has been favoured STARVE_LIMIT times in a row.
    always_comb begin
        grant_p1_s = p1_req && (!p0_req || (starve_r == STARVE_MAX));
        if (grant_p1_s) begin
            win_we_s    = p1_we;
            win_addr_s  = p1_addr;
            win_wdata_s = p1_wdata;
        end else begin
            win_we_s    = p0_we;
            win_addr_s  = p0_addr;
            win_wdata_s = p0_wdata;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        starve_s      = starve_r;
        we_s          = we_r;
        port_s        = port_r;
        p0_ack_s      = 1'b0;
        p1_ack_s      = 1'b0;
        p0_rvalid_s   = 1'b0;
        p1_rvalid_s   = 1'b0;
        p0_rdata_s    = p0_rdata;
        p1_rdata_s    = p1_rdata;
        sram_addr_s   = sram_addr;
        sram_dq_out_s = sram_dq_out;
        sram_dq_oe_s  = 1'b0;
        sram_ce_n_s   = 1'b1;
        sram_oe_n_s   = 1'b1;
        sram_we_n_s   = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    state_s       = ST_ACCESS;
                    cnt_s         = 4'd0;
                    we_s          = win_we_s;
                    port_s        = grant_p1_s;
                    p0_ack_s      = !grant_p1_s;
                    p1_ack_s      = grant_p1_s;
                    sram_addr_s   = win_addr_s;
                    sram_dq_out_s = win_wdata_s;
                    sram_ce_n_s   = 1'b0;
                    sram_oe_n_s   = win_we_s;
                    sram_dq_oe_s  = win_we_s;
                    sram_we_n_s   = !(win_we_s && (WAIT_LAST != 4'd0));
                    if (grant_p1_s || !p1_req) begin
                        starve_s = 4'd0;
                    end else if (starve_r < STARVE_MAX) begin
                        starve_s = starve_r + 4'd1;
                    end else begin
                        starve_s = starve_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == WAIT_LAST) begin
                    // Last strobe cycle: capture pad data and release the bus for turnaround.
                    state_s = ST_TURN;
                    cnt_s   = 4'd0;
                    if (!we_r && port_r) begin
                        p1_rvalid_s = 1'b1;
                        p1_rdata_s  = sram_dq_in;
                    end else if (!we_r) begin
                        p0_rvalid_s = 1'b1;
                        p0_rdata_s  = sram_dq_in;
                    end else begin
                        p0_rvalid_s = 1'b0;
                        p1_rvalid_s = 1'b0;
                    end
                end else begin
                    cnt_s        = cnt_r + 4'd1;
                    sram_ce_n_s  = 1'b0;
                    sram_oe_n_s  = we_r;
                    sram_dq_oe_s = we_r;
                    sram_we_n_s  = !(we_r && ((cnt_r + 4'd1) != WAIT_LAST));
                end
            end
            ST_TURN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            starve_r    <= 4'd0;
            we_r        <= 1'b0;
            port_r      <= 1'b0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rvalid   <= 1'b0;
            p1_rvalid   <= 1'b0;
            p0_rdata    <= {DATA_WIDTH{1'b0}};
            p1_rdata    <= {DATA_WIDTH{1'b0}};
            sram_addr   <= {ADDR_WIDTH{1'b0}};
            sram_dq_out <= {DATA_WIDTH{1'b0}};
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            starve_r    <= starve_s;
            we_r        <= we_s;
            port_r      <= port_s;
            p0_ack      <= p0_ack_s;
            p1_ack      <= p1_ack_s;
            p0_rvalid   <= p0_rvalid_s;
            p1_rvalid   <= p1_rvalid_s;
            p0_rdata    <= p0_rdata_s;
            p1_rdata    <= p1_rdata_s;
            sram_addr   <= sram_addr_s;
            sram_dq_out <= sram_dq_out_s;
            sram_dq_oe  <= sram_dq_oe_s;
            sram_ce_n   <= sram_ce_n_s;
            sram_oe_n   <= sram_oe_n_s;
            sram_we_n   <= sram_we_n_s;
        end
    end
endmodule
